// File: rtl/mono_rx_fifo_arbiter.sv
// Round-robin merge of N_SRC receiver word FIFOs into one registered valid/ready stream.
// Define MONO_ARB_BURST_EN to hold a grant for up to MAX_BURST words; otherwise one word per grant.
module mono_rx_fifo_arbiter #(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [N_SRC-1:0]     SRC_ENABLE,
    input  logic [N_SRC-1:0]     SRC_EMPTY,
    input  logic [32*N_SRC-1:0]  SRC_DATA,
    output logic [N_SRC-1:0]     SRC_READ,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2:0]           GRANT,
    output logic [31:0]          WORD_CNT
);

    typedef enum logic {ARB, SERVE} state_t;

    state_t          state;
    logic [2:0]      last;
    logic [7:0]      en8, empty8, req8, rd8;
    logic [7:0][31:0] data8;
    logic            found;
    logic [2:0]      nxt;
    logic            slot_free, gvalid, pop, burst_last;

    // Pad source vectors to the 3-bit index space so GRANT can index them directly.
    assign en8    = 8'(SRC_ENABLE);
    assign empty8 = 8'(SRC_EMPTY);
    assign data8  = 256'(SRC_DATA);
    assign req8   = en8 & ~empty8;

    always_comb begin
        int idx;
        found = 1'b0;
        nxt   = last;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last) + k) % N_SRC;
            if (!found && req8[3'(idx)]) begin
                found = 1'b1;
                nxt   = 3'(idx);
            end
        end
    end

    assign slot_free = !OUT_VALID || OUT_READY;
    assign gvalid    = en8[GRANT] && !empty8[GRANT];
    assign pop       = (state == SERVE) && slot_free && gvalid;
    assign rd8       = pop ? (8'd1 << GRANT) : 8'd0;
    assign SRC_READ  = rd8[N_SRC-1:0];

`ifdef MONO_ARB_BURST_EN
    logic [7:0] burst_cnt;
    assign burst_last = (burst_cnt == 8'(MAX_BURST - 1));
`else
    assign burst_last = 1'b1;
`endif

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= ARB;
            last      <= 3'(N_SRC - 1);
            GRANT     <= 3'd0;
            OUT_DATA  <= 32'd0;
            OUT_VALID <= 1'b0;
            WORD_CNT  <= 32'd0;
`ifdef MONO_ARB_BURST_EN
            burst_cnt <= 8'd0;
`endif
        end else begin
            // A pop refills the slot even when the old word leaves this same cycle.
            if (pop) begin
                OUT_DATA  <= data8[GRANT];
                OUT_VALID <= 1'b1;
                WORD_CNT  <= WORD_CNT + 32'd1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            case (state)
                ARB: begin
                    if (found) begin
                        GRANT <= nxt;
                        last  <= nxt;
                        state <= SERVE;
`ifdef MONO_ARB_BURST_EN
                        burst_cnt <= 8'd0;
`endif
                    end
                end
                SERVE: begin
                    if (!gvalid) begin
                        state <= ARB;
                    end else if (pop) begin
`ifdef MONO_ARB_BURST_EN
                        burst_cnt <= burst_cnt + 8'd1;
`endif
                        if (burst_last)
                            state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mono_rx_fifo_arbiter.sv
// Directed bench for mono_rx_fifo_arbiter: per-source FIFO model, output log, hand-computed orders.
module tb_mono_rx_fifo_arbiter;

    localparam int N = 4;
`ifdef MONO_ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    logic            BUS_CLK, BUS_RST;
    logic [N-1:0]    SRC_ENABLE, SRC_EMPTY, SRC_READ;
    logic [32*N-1:0] SRC_DATA;
    logic [31:0]     OUT_DATA, WORD_CNT;
    logic            OUT_VALID, OUT_READY;
    logic [2:0]      GRANT;

    logic [31:0] mem [N][16];
    int          head [N];
    int          tail [N];
    logic [31:0] rx [64];
    int          rx_n;
    int          n_tests, n_fail;

    mono_rx_fifo_arbiter #(.N_SRC(N), .MAX_BURST(4)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
        .SRC_ENABLE(SRC_ENABLE), .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA),
        .SRC_READ(SRC_READ), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .GRANT(GRANT), .WORD_CNT(WORD_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int s, input int n);
        return {16'(32'hA000 + s), 16'(n)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            SRC_EMPTY[i] = (head[i] >= tail[i]);
            SRC_DATA[32*i +: 32] = (head[i] < tail[i]) ? mem[i][head[i]] : 32'd0;
        end
    endtask

    task automatic fill(input int s, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            mem[s][tail[s]] = wd(s, n);
            tail[s]++;
        end
    endtask

    // One clock: sample handshakes mid-cycle, then apply pops and log accepted words after the edge.
    task automatic step();
        logic [N-1:0] rd;
        logic         ov, rdy;
        logic [31:0]  od;
        @(negedge BUS_CLK);
        rd = SRC_READ; ov = OUT_VALID; od = OUT_DATA; rdy = OUT_READY;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N; i++)
            if (rd[i] && head[i] < tail[i]) head[i]++;
        if (ov && rdy && rx_n < 64) begin
            rx[rx_n] = od;
            rx_n++;
        end
        drive();
    endtask

    task automatic reset_on();
        BUS_RST = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rx_n = 0;
        drive();
    endtask

    task automatic reset_off();
        @(posedge BUS_CLK);
        #1;
        BUS_RST = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        int          s;
        n_tests = 0; n_fail = 0; rx_n = 0;
        BUS_RST = 1'b0; SRC_ENABLE = '1; OUT_READY = 1'b1;
        SRC_EMPTY = '1; SRC_DATA = '0;
        #2;

        // Reset values, then 4 full sources drained round-robin
        reset_on();
        chk("rst_read",  32'(SRC_READ), 32'd0);
        chk("rst_data",  OUT_DATA, 32'd0);
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_cnt",   WORD_CNT, 32'd0);
        for (int i = 0; i < N; i++) fill(i, 3);
        drive();
        reset_off();
        repeat (40) step();
        chk("rr_count", 32'(rx_n), 32'd12);
        for (int k = 0; k < 12; k++) begin
            e = (BL == 1) ? wd(k % 4, k / 4) : wd(k / 3, k % 3);
            chk($sformatf("rr_word%0d", k), rx[k], e);
        end
        chk("rr_wordcnt", WORD_CNT, 32'd12);
        chk("rr_valid_end", 32'(OUT_VALID), 32'd0);

        // Single requester src2, then backpressure on its pending word
        reset_on();
        OUT_READY = 1'b0;
        fill(2, 2);
        drive();
        reset_off();
        step();
        chk("one_grant", 32'(GRANT), 32'd2);
        chk("one_read",  32'(SRC_READ), 32'b0100);
        step();
        chk("one_valid", 32'(OUT_VALID), 32'd1);
        chk("one_data",  OUT_DATA, wd(2, 0));
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_data%0d", c), OUT_DATA, wd(2, 0));
            chk($sformatf("bp_read%0d", c), 32'(SRC_READ), 32'd0);
        end
        OUT_READY = 1'b1;
        drive();
        step();
        chk("bp_acc_n",    32'(rx_n), 32'd1);
        chk("bp_acc_word", rx[0], wd(2, 0));
        chk("bp_next",     OUT_DATA, wd(2, 1));
        chk("bp_wordcnt",  WORD_CNT, 32'd2);

        // Disabled src2 is skipped
        reset_on();
        SRC_ENABLE = 4'b1011;
        for (int i = 0; i < N; i++) fill(i, 2);
        drive();
        reset_off();
        repeat (30) step();
        chk("en_count", 32'(rx_n), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (BL == 1) begin
                s = (k % 3 == 2) ? 3 : k % 3;
                e = wd(s, k / 3);
            end else begin
                s = (k / 2 == 2) ? 3 : k / 2;
                e = wd(s, k % 2);
            end
            chk($sformatf("en_word%0d", k), rx[k], e);
        end
        chk("en_src2_untouched", 32'(head[2]), 32'd0);

`ifdef MONO_ARB_BURST_EN
        // Burst of 4: 4x src0, 2x src1, 4x src0, 2x src0
        reset_on();
        SRC_ENABLE = '1;
        fill(0, 10);
        fill(1, 2);
        drive();
        reset_off();
        repeat (40) step();
        chk("bu_count", 32'(rx_n), 32'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < 4)       e = wd(0, k);
            else if (k < 6)  e = wd(1, k - 4);
            else             e = wd(0, k - 2);
            chk($sformatf("bu_word%0d", k), rx[k], e);
        end
`endif

        // Reset while a word is held in the output register
        reset_on();
        SRC_ENABLE = 4'b1110;
        OUT_READY = 1'b0;
        for (int i = 0; i < N; i++) fill(i, 3);
        drive();
        reset_off();
        step();
        step();
        chk("mr_pre_valid", 32'(OUT_VALID), 32'd1);
        chk("mr_pre_grant", 32'(GRANT), 32'd1);
        BUS_RST = 1'b1;
        #1;
        chk("mr_valid", 32'(OUT_VALID), 32'd0);
        chk("mr_data",  OUT_DATA, 32'd0);
        chk("mr_grant", 32'(GRANT), 32'd0);
        chk("mr_cnt",   WORD_CNT, 32'd0);
        chk("mr_read",  32'(SRC_READ), 32'd0);
        SRC_ENABLE = '1;
        OUT_READY = 1'b1;
        drive();
        reset_off();
        step();
        chk("mr_first_grant", 32'(GRANT), 32'd0);
        chk("mr_first_read",  32'(SRC_READ), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mono_rx_fifo_arbiter.md
# mono_rx_fifo_arbiter

Round-robin arbiter that merges the 32-bit word FIFOs of several `mono_data_rx` receiver instances into a single word stream for the downstream readout FIFO / SiTCP path. It sits between the receivers' `FIFO_READ`/`FIFO_EMPTY`/`FIFO_DATA` ports and one registered output stage with a valid/ready handshake. It guarantees fair service of all enabled receivers and never drops or duplicates a word.

## Interface
Parameters:
- `N_SRC`, 4: number of receiver sources, legal range 2..8.
- `MAX_BURST`, 16: maximum words per grant. Used only with `MONO_ARB_BURST_EN`. Legal range 1..255.

Ports:
- `BUS_CLK` in 1: single clock; all logic is in this domain.
- `BUS_RST` in 1: reset, asynchronous, active-high.
- `SRC_ENABLE` in N_SRC: per-source enable mask; a disabled source is never granted.
- `SRC_EMPTY` in N_SRC: receiver `FIFO_EMPTY` flags.
- `SRC_DATA` in 32*N_SRC: receiver `FIFO_DATA`; source i occupies bits [32*i+31:32*i]. First-word-fall-through: valid whenever `SRC_EMPTY[i]`=0.
- `SRC_READ` out N_SRC: receiver `FIFO_READ`; pops the presented word in the same cycle.
- `OUT_DATA` out 32: merged word, registered.
- `OUT_VALID` out 1: `OUT_DATA` holds an unconsumed word.
- `OUT_READY` in 1: downstream accepts the word when `OUT_VALID`=1 and `OUT_READY`=1.
- `GRANT` out 3: index of the currently granted source; valid in SERVE.
- `WORD_CNT` out 32: total words forwarded to the output register.

## Operation
- FSM states: ARB and SERVE. Reset state is ARB.
- ARB:
  - Search for a requester: `SRC_ENABLE[i]`=1 and `SRC_EMPTY[i]`=0.
  - Search order: `last+1`, `last+2`, … modulo N_SRC. `last` is the most recently granted index and resets to N_SRC-1, so source 0 is searched first after reset.
  - If a requester is found: register `GRANT`=i and `last`=i, clear the burst counter, go to SERVE.
  - If none is found: stay in ARB. `SRC_READ`=0.
- SERVE:
  - Output slot free = `OUT_VALID`=0, or (`OUT_VALID`=1 and `OUT_READY`=1).
  - Pop condition: slot free and `SRC_ENABLE[GRANT]`=1 and `SRC_EMPTY[GRANT]`=0.
  - When the pop condition holds: `SRC_READ[GRANT]`=1, which is one-hot and combinational from registered state plus inputs. `SRC_DATA[GRANT]` is loaded into `OUT_DATA`, and the burst counter and `WORD_CNT` increment.
  - Return to ARB on the cycle after a pop that reaches the burst limit.
  - Also return to ARB on any SERVE cycle with `SRC_EMPTY[GRANT]`=1 or `SRC_ENABLE[GRANT]`=0; no pop occurs in that cycle.
  - Burst limit is 1 word without the macro, `MAX_BURST` with it.
- Output register:
  - Set `OUT_VALID`=1 on a pop.
  - Clear `OUT_VALID` when the word is consumed and no pop happens in the same cycle.
  - Simultaneous consume and pop: `OUT_VALID` stays 1 and the new word replaces the old one.
- `WORD_CNT` wraps from 2^32-1 to 0.
- Words are forwarded unmodified; the source identifier is already carried in the word by each receiver.

## Timing
- Reset values: `SRC_READ`=0, `OUT_DATA`=0, `OUT_VALID`=0, `GRANT`=0, `WORD_CNT`=0, state=ARB, `last`=N_SRC-1.
- Arbitration latency: 1 cycle (ARB to SERVE). The first `SRC_READ` pulse comes in the first SERVE cycle at the earliest.
- Pop to `OUT_VALID`/`OUT_DATA` visible: 1 cycle.
- Throughput without burst: 1 word per 2 cycles.
- Throughput with burst: up to `MAX_BURST` words per `MAX_BURST`+1 cycles.
- Backpressure: while `OUT_VALID`=1 and `OUT_READY`=0:
  - `OUT_DATA` is held stable.
  - `SRC_READ`=0.
  - The FSM stays in SERVE; the burst counter does not advance.
- `SRC_ENABLE` falling during SERVE: no pop in that cycle, back to ARB next cycle.
- Asserting `BUS_RST` mid-transfer discards any word in the output register. A word already popped from a receiver is lost, by design.

## Configuration
- `MONO_ARB_BURST_EN` defined: a grant is held for up to `MAX_BURST` consecutive words, then the FSM re-arbitrates.
- `MONO_ARB_BURST_EN` undefined: exactly one word per grant, and the `MAX_BURST` logic is not synthesized.

## Test plan
- After reset, N_SRC=4 with all sources enabled and each holding 3 words, `OUT_READY`=1, no burst: output order is src0,src1,src2,src3 repeated; 12 words in total; `WORD_CNT`=12; no word duplicated.
- Only src2 non-empty after reset: `GRANT`=2 after 1 cycle; `SRC_READ[2]` pulses; the word appears on `OUT_DATA` one cycle later.
- With a word pending, hold `OUT_READY`=0 for 5 cycles: `OUT_DATA` stays constant, `SRC_READ`=0 throughout, and the word is accepted on the first `OUT_READY`=1.
- `SRC_ENABLE`=4'b1011 with all sources full: src2 is never read; order is 0,1,3,0,1,3.
- `MONO_ARB_BURST_EN`, `MAX_BURST`=4, src0 with 10 words and src1 with 2 words: order is 4×src0, 2×src1, 4×src0, 2×src0.
- Assert `BUS_RST` while `OUT_VALID`=1: all outputs return to reset values immediately, and the first grant after release is src0.
